// File: rtl/ptw_req_sched_pkg.sv
// Shared MMU types for the page-table-walker request scheduler.
// Scheduler states, default sizing and the TLB<->PTW request/response records.
package ptw_req_sched_pkg;

  localparam int PTW_NUM_REQ  = 2;
  localparam int PTW_TIMEOUT  = 1023;
  localparam int PTW_VPN_SIZE = 27;
  localparam int PTW_PPN_SIZE = 44;
  localparam int PTW_LEVEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } sched_state_t;

  typedef struct packed {
    logic [PTW_VPN_SIZE-1:0] vpn;
    logic [1:0]              prv;
    logic                    store;
    logic                    fetch;
  } tlb_ptw_req_t;

  typedef struct packed {
    logic                     error;
    logic [PTW_LEVEL_W-1:0]   level;
    logic [PTW_PPN_SIZE+9:0]  pte;
  } ptw_tlb_resp_t;

endpackage

// File: rtl/ptw_req_sched_rr_picker.sv
// Combinational rotate-priority encoder: lowest valid index at or above ptr, else lowest overall.
// Zero latency; no state, no backpressure.
module rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    // Second pass overrides the wrap-around choice whenever something sits at/above ptr.
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[i]) idx = PTR_W'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[i] && (PTR_W'(i) >= ptr)) idx = PTR_W'(i);
    end
    any = |valid;
  end

endmodule

// File: rtl/ptw_req_sched.sv
// Round-robin share of one page-table walker among NUM_REQ TLBs; ack and response are same-cycle.
// One walk outstanding; requesters hold valid until acked, walker gates issue with ptw_ready_i.
module ptw_req_sched
  import ptw_req_sched_pkg::*;
#(
  parameter int NUM_REQ  = PTW_NUM_REQ,
  parameter int VPN_SIZE = PTW_VPN_SIZE,
  parameter int PPN_SIZE = PTW_PPN_SIZE,
  parameter int LEVEL_W  = PTW_LEVEL_W,
  parameter int TIMEOUT  = PTW_TIMEOUT
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*VPN_SIZE-1:0] req_vpn_i,
  input  logic [NUM_REQ*2-1:0]        req_prv_i,
  input  logic [NUM_REQ-1:0]          req_store_i,
  input  logic [NUM_REQ-1:0]          req_fetch_i,
  output logic [NUM_REQ-1:0]          req_ack_o,
  output logic [NUM_REQ-1:0]          resp_valid_o,
  output logic                        resp_error_o,
  output logic [LEVEL_W-1:0]          resp_level_o,
  output logic [PPN_SIZE+9:0]         resp_pte_o,
  output logic                        ptw_req_valid_o,
  output logic [VPN_SIZE-1:0]         ptw_req_vpn_o,
  output logic [1:0]                  ptw_req_prv_o,
  output logic                        ptw_req_store_o,
  output logic                        ptw_req_fetch_o,
  input  logic                        ptw_ready_i,
  input  logic                        ptw_resp_valid_i,
  input  logic                        ptw_resp_error_i,
  input  logic [LEVEL_W-1:0]          ptw_resp_level_i,
  input  logic [PPN_SIZE+9:0]         ptw_resp_pte_i,
  input  logic                        flush_i,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  sched_state_t     state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] winner;
  logic [WD_W-1:0]  wd_cnt;
  logic             any_vld;
  logic             issue;
  logic             accept;
  logic             resp_fire;
  logic             wd_fire;

  rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .valid (req_valid_i),
    .ptr   (rr_ptr),
    .idx   (winner),
    .any   (any_vld)
  );

  assign issue     = (state == IDLE) && any_vld && !flush_i;
  assign accept    = issue && ptw_ready_i;
  assign resp_fire = (state == WAIT) && ptw_resp_valid_i && !flush_i;
  // A real response or a flush in the same cycle always beats the watchdog.
  assign wd_fire   = (TIMEOUT != 0) && (state == WAIT) && !ptw_resp_valid_i && !flush_i &&
                     (wd_cnt == WD_LAST);

  always_comb begin
    req_ack_o    = '0;
    resp_valid_o = '0;
    if (accept) req_ack_o[winner] = 1'b1;
    if (resp_fire || wd_fire) resp_valid_o[owner] = 1'b1;
  end

  assign ptw_req_valid_o = issue;
  assign ptw_req_vpn_o   = issue ? req_vpn_i[int'(winner)*VPN_SIZE +: VPN_SIZE] : '0;
  assign ptw_req_prv_o   = issue ? req_prv_i[int'(winner)*2 +: 2] : '0;
  assign ptw_req_store_o = issue && req_store_i[winner];
  assign ptw_req_fetch_o = issue && req_fetch_i[winner];

  assign resp_error_o = resp_fire ? ptw_resp_error_i : wd_fire;
  assign resp_level_o = resp_fire ? ptw_resp_level_i : '0;
  assign resp_pte_o   = resp_fire ? ptw_resp_pte_i : '0;
  assign busy_o       = (state != IDLE);
  assign timeout_o    = wd_fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner  <= winner;
            rr_ptr <= (winner == PTR_LAST) ? '0 : winner + 1'b1;
            wd_cnt <= '0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
          if (ptw_resp_valid_i)        state <= IDLE;
          else if (flush_i || wd_fire) state <= DRAIN;
        end
        DRAIN: begin
          // The walker's late answer (or it going idle) closes the abandoned walk.
          if (ptw_resp_valid_i || ptw_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
